// File: rtl/rvvi_trace_serializer_if.sv
// Retire-port and serialized-output bundle for the RVVI trace serializer.
// Slot index is h*RETIRE+s on every in_* array.
interface rvvi_trace_serializer_if #(
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int NHART  = 2,
  parameter int RETIRE = 2
);
  localparam int NS = NHART * RETIRE;
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;

  logic [NS-1:0]           in_valid;
  logic [NS-1:0][63:0]     in_order;
  logic [NS-1:0][XLEN-1:0] in_pc;
  logic [NS-1:0][ILEN-1:0] in_insn;
  logic [NS-1:0]           in_trap;

  logic            out_valid;
  logic            out_ready;
  logic [HW-1:0]   out_hart;
  logic [63:0]     out_order;
  logic [XLEN-1:0] out_pc;
  logic [ILEN-1:0] out_insn;
  logic            out_trap;

  modport master (
    output in_valid, in_order, in_pc, in_insn, in_trap, out_ready,
    input  out_valid, out_hart, out_order, out_pc, out_insn, out_trap
  );
  modport slave (
    input  in_valid, in_order, in_pc, in_insn, in_trap, out_ready,
    output out_valid, out_hart, out_order, out_pc, out_insn, out_trap
  );
endinterface

// File: rtl/rvvi_trace_serializer.sv
// Per-hart compacting retire FIFOs with order checking, merged onto one
// event stream by a round-robin arbiter that locks its grant while stalled.
module rvvi_trace_lane #(
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 8,
  parameter int NW     = $clog2(RETIRE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      err_clr,
  input  logic [RETIRE-1:0]         in_valid,
  input  logic [RETIRE-1:0][63:0]   in_order,
  input  logic [RETIRE-1:0][XLEN-1:0] in_pc,
  input  logic [RETIRE-1:0][ILEN-1:0] in_insn,
  input  logic [RETIRE-1:0]         in_trap,
  input  logic                      pop,
  output logic                      nempty,
  output logic [64+XLEN+ILEN:0]     head,
  output logic                      overflow,
  output logic                      order_err,
  output logic [NW-1:0]             drop_n
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = 65 + XLEN + ILEN;

  logic [PW-1:0]              mem [DEPTH];
  logic [AW:0]                cnt;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [63:0]                exp_ord, nxt_ord;
  logic                       exp_v, nxt_v, err;
  logic [NW-1:0]              n;
  logic [RETIRE-1:0][AW-1:0]  off;
  logic [AW-1:0]              o;
  logic                       accept;

  // Compaction offsets and slot-sequential order check over this cycle's slots
  always_comb begin
    n       = '0;
    o       = '0;
    off     = '0;
    nxt_ord = exp_ord;
    nxt_v   = exp_v;
    err     = 1'b0;
    for (int s = 0; s < RETIRE; s++) begin
      off[s] = o;
      if (in_valid[s]) begin
        o = o + 1'b1;
        n = n + 1'b1;
        if (nxt_v && in_order[s] != nxt_ord) err = 1'b1;
        nxt_ord = in_order[s] + 64'd1;
        nxt_v   = 1'b1;
      end
    end
    // Room is judged on the pre-pop count so a same-cycle pop never frees space
    accept = (DEPTH - int'(cnt)) >= int'(n);
    drop_n = accept ? '0 : n;
  end

  always_ff @(posedge clk) begin
    if (!reset && accept)
      for (int s = 0; s < RETIRE; s++)
        if (in_valid[s])
          mem[wr_ptr + off[s]] <= {in_order[s], in_pc[s], in_insn[s], in_trap[s]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      exp_ord   <= '0;
      exp_v     <= 1'b0;
      overflow  <= 1'b0;
      order_err <= 1'b0;
    end else begin
      wr_ptr    <= wr_ptr + (accept ? AW'(n) : '0);
      rd_ptr    <= rd_ptr + AW'(pop);
      cnt       <= cnt + (accept ? (AW+1)'(n) : '0) - (AW+1)'(pop);
      if (accept) begin
        exp_ord <= nxt_ord;
        exp_v   <= nxt_v;
      end
      overflow  <= (overflow & ~err_clr) | (drop_n != '0);
      order_err <= (order_err & ~err_clr) | (accept & err);
    end
  end

  assign nempty = (cnt != '0);
  assign head   = mem[rd_ptr];
endmodule

module rvvi_trace_serializer #(
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int NHART  = 2,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 err_clr,
  rvvi_trace_serializer_if.slave bus,
  output logic [NHART-1:0]     overflow,
  output logic [NHART-1:0]     order_err,
  output logic [15:0]          drop_cnt
);
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int PW = 65 + XLEN + ILEN;
  localparam int NW = $clog2(RETIRE + 1);

  logic [NHART-1:0]          nempty, pop;
  logic [NHART-1:0][PW-1:0]  head;
  logic [NHART-1:0][NW-1:0]  drop_n;
  logic [HW-1:0]             rr_ptr, held_hart, gnt;
  logic                      held, fire;
  logic [16:0]               dsum;
  int                        best, d;

  for (genvar h = 0; h < NHART; h++) begin : g_lane
    rvvi_trace_lane #(.ILEN(ILEN), .XLEN(XLEN), .RETIRE(RETIRE), .DEPTH(DEPTH), .NW(NW)) u_lane (
      .clk       (clk),
      .reset     (reset),
      .err_clr   (err_clr),
      .in_valid  (bus.in_valid[h*RETIRE +: RETIRE]),
      .in_order  (bus.in_order[h*RETIRE +: RETIRE]),
      .in_pc     (bus.in_pc[h*RETIRE +: RETIRE]),
      .in_insn   (bus.in_insn[h*RETIRE +: RETIRE]),
      .in_trap   (bus.in_trap[h*RETIRE +: RETIRE]),
      .pop       (pop[h]),
      .nempty    (nempty[h]),
      .head      (head[h]),
      .overflow  (overflow[h]),
      .order_err (order_err[h]),
      .drop_n    (drop_n[h])
    );
    assign pop[h] = fire && (gnt == HW'(h));
  end

  // Nearest non-empty hart at or after rr_ptr; a stalled grant stays locked
  always_comb begin
    gnt  = held_hart;
    best = NHART;
    d    = 0;
    if (!held) begin
      gnt = rr_ptr;
      for (int h = 0; h < NHART; h++) begin
        d = h - int'(rr_ptr);
        if (d < 0) d = d + NHART;
        if (nempty[h] && d < best) begin
          best = d;
          gnt  = HW'(h);
        end
      end
    end
  end

  assign bus.out_valid = |nempty;
  assign fire          = bus.out_valid && bus.out_ready;
  assign {bus.out_order, bus.out_pc, bus.out_insn, bus.out_trap} = head[gnt];
  assign bus.out_hart  = gnt;

  always_comb begin
    dsum = {1'b0, drop_cnt};
    for (int h = 0; h < NHART; h++) dsum = dsum + 17'(drop_n[h]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      held      <= 1'b0;
      held_hart <= '0;
      drop_cnt  <= '0;
    end else begin
      held      <= bus.out_valid && !bus.out_ready;
      held_hart <= gnt;
      if (fire) rr_ptr <= (gnt == HW'(NHART - 1)) ? '0 : gnt + 1'b1;
      drop_cnt  <= dsum[16] ? 16'hFFFF : dsum[15:0];
    end
  end
endmodule

// File: tb/tb_rvvi_trace_serializer.sv
// Randomized scoreboard bench: a queue-based model predicts accepted events,
// drops, flags and arbitration; a negedge monitor checks each handshake.
module tb_rvvi_trace_serializer;
  localparam int ILEN = 32, XLEN = 32, NHART = 2, RETIRE = 2, DEPTH = 8;
  localparam int NS = NHART * RETIRE;
  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;

  typedef struct packed {
    logic [HW-1:0]   hart;
    logic [63:0]     order;
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] insn;
    logic            trap;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1, err_clr = 1'b0;
  logic [NHART-1:0] overflow, order_err;
  logic [15:0] drop_cnt;

  rvvi_trace_serializer_if #(.ILEN(ILEN), .XLEN(XLEN), .NHART(NHART), .RETIRE(RETIRE)) bus ();

  rvvi_trace_serializer #(.ILEN(ILEN), .XLEN(XLEN), .NHART(NHART), .RETIRE(RETIRE), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .err_clr(err_clr), .bus(bus.slave),
    .overflow(overflow), .order_err(order_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  ev_t              mq [NHART][$];
  ev_t              exp_q [$];
  logic [63:0]      m_exp [NHART];
  bit               m_ev [NHART];
  logic [63:0]      nxt_ord [NHART];
  logic [NHART-1:0] m_ovf, m_oerr;
  int               m_dcnt, m_ptr, m_hg;
  bit               m_hold;
  int               n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cycle(input logic [NS-1:0] iv, input bit rdy, input bit clr, input bit rst,
                       input logic [NHART-1:0] gap);
    ev_t e;
    int  g, n, idx;
    bit  mv, found, any;
    reset = rst; err_clr = clr; bus.out_ready = rdy && !rst; bus.in_valid = iv;
    for (int h = 0; h < NHART; h++) begin
      if (gap[h]) nxt_ord[h] += 64'd1 + 64'($urandom_range(0, 3));
      for (int s = 0; s < RETIRE; s++) begin
        idx = h * RETIRE + s;
        bus.in_order[idx] = nxt_ord[h];
        if (iv[idx]) nxt_ord[h] += 64'd1;
        bus.in_pc[idx]   = $urandom;
        bus.in_insn[idx] = $urandom;
        bus.in_trap[idx] = ($urandom_range(0, 7) == 0);
      end
    end
    if (rst) begin
      for (int h = 0; h < NHART; h++) begin mq[h].delete(); m_ev[h] = 0; end
      m_ovf = '0; m_oerr = '0; m_dcnt = 0; m_ptr = 0; m_hold = 0; m_hg = 0;
    end else begin
      mv = 0;
      for (int h = 0; h < NHART; h++) if (mq[h].size() != 0) mv = 1;
      g = 0; found = 0;
      if (m_hold) g = m_hg;
      else for (int i = 0; i < NHART; i++)
        if (!found && mq[(m_ptr + i) % NHART].size() != 0) begin g = (m_ptr + i) % NHART; found = 1; end
      if (clr) begin m_ovf = '0; m_oerr = '0; end
      for (int h = 0; h < NHART; h++) begin
        n = 0;
        for (int s = 0; s < RETIRE; s++) n += int'(iv[h*RETIRE+s]);
        if (DEPTH - mq[h].size() >= n) begin
          for (int s = 0; s < RETIRE; s++) begin
            idx = h * RETIRE + s;
            if (iv[idx]) begin
              e = {HW'(h), bus.in_order[idx], bus.in_pc[idx], bus.in_insn[idx], bus.in_trap[idx]};
              if (m_ev[h] && e.order != m_exp[h]) m_oerr[h] = 1'b1;
              m_exp[h] = e.order + 64'd1;
              m_ev[h]  = 1;
              mq[h].push_back(e);
            end
          end
        end else begin
          m_ovf[h] = 1'b1;
          m_dcnt   = (m_dcnt + n > 65535) ? 65535 : m_dcnt + n;
        end
      end
      if (mv && rdy) begin
        exp_q.push_back(mq[g].pop_front());
        m_ptr = (g + 1) % NHART;
      end
      m_hold = mv && !rdy;
      m_hg   = g;
    end
    @(posedge clk); #1;
    any = 0;
    for (int h = 0; h < NHART; h++) if (mq[h].size() != 0) any = 1;
    chk("out_valid", bus.out_valid, any);
    chk("overflow", overflow, m_ovf);
    chk("order_err", order_err, m_oerr);
    chk("drop_cnt", drop_cnt, m_dcnt);
  endtask

  // Monitor: compare every handshake against the scoreboard; check stall stability
  initial begin
    ev_t cur, st_pay, e;
    bit  st_prev;
    st_prev = 0; st_pay = '0;
    forever begin
      @(negedge clk);
      cur = {bus.out_hart, bus.out_order, bus.out_pc, bus.out_insn, bus.out_trap};
      if (st_prev) chk("stall_hold", {bus.out_valid, cur}, {1'b1, st_pay});
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) chk("unexpected_event", cur, '0);
        else begin
          e = exp_q.pop_front();
          chk("out_event", cur, e);
        end
      end
      st_prev = (bus.out_valid === 1'b1) && !bus.out_ready && !reset;
      st_pay  = cur;
    end
  end

  initial begin
    bus.out_ready = 1'b0; bus.in_valid = '0; bus.in_order = '0;
    bus.in_pc = '0; bus.in_insn = '0; bus.in_trap = '0;
    for (int h = 0; h < NHART; h++) begin nxt_ord[h] = 64'(h * 1000); m_ev[h] = 0; m_exp[h] = '0; end
    m_ovf = '0; m_oerr = '0; m_dcnt = 0; m_ptr = 0; m_hold = 0; m_hg = 0;

    repeat (2) cycle('0, 0, 0, 1, '0);
    // Two harts same cycle, slot compaction on hart1
    cycle(4'b1011, 1, 0, 0, '0);
    repeat (4) cycle('0, 1, 0, 0, '0);
    // Order gap on hart0, then clear
    cycle(4'b0001, 1, 0, 0, '0);
    cycle(4'b0001, 1, 0, 0, 2'b01);
    cycle(4'b0001, 1, 0, 0, '0);
    repeat (3) cycle('0, 1, 0, 0, '0);
    cycle('0, 1, 1, 0, '0);
    // Fill to 7, 2-slot drop, 1-slot fits to 8, then full with pop drops push
    repeat (3) cycle(4'b0011, 0, 0, 0, '0);
    cycle(4'b0001, 0, 0, 0, '0);
    cycle(4'b0011, 0, 0, 0, '0);
    cycle(4'b0001, 0, 0, 0, '0);
    cycle(4'b0001, 1, 0, 0, '0);
    repeat (10) cycle('0, 1, 0, 0, '0);
    // Both harts loaded, ready toggling
    repeat (2) cycle(4'b1111, 0, 1, 0, '0);
    for (int c = 0; c < 14; c++) cycle('0, c[0], 0, 0, '0);
    // Reset with buffered events
    repeat (2) cycle(4'b0011, 0, 0, 0, '0);
    cycle(4'b0001, 0, 0, 0, '0);
    cycle(4'b1111, 0, 0, 1, '0);
    cycle('0, 1, 0, 0, '0);
    // Random traffic, ready duty varies per phase so overflow gets exercised
    for (int c = 0; c < 3000; c++)
      cycle(NS'($urandom), $urandom_range(0, 3) < (c / 200) % 4, $urandom_range(0, 49) == 0,
            $urandom_range(0, 499) == 0,
            {($urandom_range(0, 19) == 0), ($urandom_range(0, 19) == 0)});
    repeat (40) cycle('0, 1, 0, 0, '0);
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
